if_id_pipe: RTL and testbench

- IF/ID pipeline register of the five-stage CPU. Sits directly downstream of the instruction-fetch stage and upstream of decode.
- Captures the fetched instruction, its PC and PC+4 each cycle.
- Detects load-use hazards against the instruction in EX and stalls fetch via a PC write enable.
- Squashes the fetched instruction when a branch or jump redirects the PC, and keeps saturating stall and flush event counters.

---
 rtl/if_id_pipe.sv | 133 +++++++++++++
 tb/tb_if_id_pipe.sv | 137 +++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register for the five-stage CPU.
// Captures the fetched instruction, its PC and PC+4 once per cycle. It stalls
// fetch on a load-use hazard against EX and squashes the fetched instruction
// when the PC is redirected. It also keeps saturating stall and flush counters.
//
// Ports:
//   clk, clr              rising-edge clock, synchronous active-high reset
//   if_inst/if_pc/if_pc4  fetch-stage instruction, PC, PC+4
//   pcsource              next-PC select from decode (nonzero = redirect)
//   ex_m2reg/ex_wreg/ex_rd  EX-stage load flag, regfile write flag, dest reg
//   pc_we                 PC write enable (0 holds fetch)
//   stall                 load-use stall; decode must inject a bubble
//   id_inst/id_pc/id_pc4  registered fetch outputs
//   id_valid              id_inst is a live instruction
//   id_rs/id_rt           source register fields of id_inst
//   stall_cnt/flush_cnt   saturating event counters
module if_id_pipe #(
  parameter bit          FLUSH_ON_BRANCH = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_pc4,
  input  logic [1:0]       pcsource,
  input  logic             ex_m2reg,
  input  logic             ex_wreg,
  input  logic [4:0]       ex_rd,
  output logic             pc_we,
  output logic             stall,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      id_inst_q, id_inst_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic [31:0]      id_pc4_q, id_pc4_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0] opcode;
  logic       uses_rs;
  logic       uses_rt;
  logic       hazard;
  logic       redirect;

  // Register-use decode of the instruction held in ID.
  always_comb begin
    opcode  = id_inst_q[31:26];
    uses_rs = !(opcode == 6'b000010 || opcode == 6'b000011);
    uses_rt = (opcode == 6'b000000) || (opcode == 6'b101011) ||
              (opcode == 6'b000100) || (opcode == 6'b000101);
  end

  // Load-use hazard: the load in EX produces a register that ID reads.
  // A bubble in ID (id_valid = 0) never stalls.
  always_comb begin
    hazard = id_valid_q && ex_m2reg && ex_wreg && (ex_rd != 5'd0) &&
             ((uses_rs && (ex_rd == id_inst_q[25:21])) ||
              (uses_rt && (ex_rd == id_inst_q[20:16])));
    redirect = FLUSH_ON_BRANCH && (pcsource != 2'b00);
  end

  // Update priority: stall > flush > load (reset is handled in the flop block).
  // A redirect during a stall is dropped because the stalled decode is not
  // committed, so it will be re-presented once the stall clears.
  always_comb begin
    id_inst_d   = id_inst_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (redirect) begin
      id_inst_d  = '0;
      id_valid_d = 1'b0;
      id_pc_d    = if_pc;
      id_pc4_d   = if_pc4;
      if (flush_cnt_q != '1) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end else begin
      id_inst_d  = if_inst;
      id_pc_d    = if_pc;
      id_pc4_d   = if_pc4;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      id_inst_q   <= '0;
      id_pc_q     <= '0;
      id_pc4_q    <= '0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_inst_q   <= id_inst_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall     = hazard;
    pc_we     = !hazard;
    id_inst   = id_inst_q;
    id_pc     = id_pc_q;
    id_pc4    = id_pc4_q;
    id_valid  = id_valid_q;
    id_rs     = id_inst_q[25:21];
    id_rt     = id_inst_q[20:16];
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe (CNT_W = 4, FLUSH_ON_BRANCH = 1).
// The driver applies one input vector per cycle on the falling edge and
// queues the hand-computed outputs expected for that cycle. A monitor pops
// and compares shortly after each falling edge.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] if_inst, if_pc, if_pc4;
  logic [1:0]  pcsource;
  logic        ex_m2reg, ex_wreg;
  logic [4:0]  ex_rd;
  logic        pc_we, stall, id_valid;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic [4:0]  id_rs, id_rt;
  logic [3:0]  stall_cnt, flush_cnt;

  if_id_pipe #(.FLUSH_ON_BRANCH(1'b1), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4),
    .pcsource(pcsource), .ex_m2reg(ex_m2reg), .ex_wreg(ex_wreg), .ex_rd(ex_rd),
    .pc_we(pc_we), .stall(stall), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc4(id_pc4), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] inst, pc, pc4;
    logic        valid, stl;
    logic [3:0]  scnt, fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [31:0] INST_A = 32'h8C220004; // lw $2,4($1)
  localparam logic [31:0] INST_B = 32'h00851020; // add $2,$4,$5
  localparam logic [31:0] INST_C = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] INST_Z = 32'h00001020; // add $2,$0,$0
  localparam logic [31:0] INST_J = 32'h08420010; // j, rs/rt fields = 2
  localparam logic [31:0] INST_D = 32'h20210001; // addi $1,$1,1

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, want);
    end
  endtask

  task automatic step(input string nm, input logic c, input logic [31:0] inst,
                      input logic [31:0] pc, input logic [1:0] ps,
                      input logic m2, input logic wr, input logic [4:0] rd,
                      input logic [31:0] e_inst, input logic [31:0] e_pc,
                      input logic [31:0] e_pc4, input logic e_valid,
                      input logic e_stall, input logic [3:0] e_scnt,
                      input logic [3:0] e_fcnt);
    exp_t e;
    @(negedge clk);
    clr = c; if_inst = inst; if_pc = pc; if_pc4 = pc + 32'd4;
    pcsource = ps; ex_m2reg = m2; ex_wreg = wr; ex_rd = rd;
    e.nm = nm; e.inst = e_inst; e.pc = e_pc; e.pc4 = e_pc4;
    e.valid = e_valid; e.stl = e_stall; e.scnt = e_scnt; e.fcnt = e_fcnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "id_inst",   id_inst, e.inst);
        chk(e.nm, "id_pc",     id_pc, e.pc);
        chk(e.nm, "id_pc4",    id_pc4, e.pc4);
        chk(e.nm, "id_valid",  {31'd0, id_valid}, {31'd0, e.valid});
        chk(e.nm, "id_rs",     {27'd0, id_rs}, {27'd0, e.inst[25:21]});
        chk(e.nm, "id_rt",     {27'd0, id_rt}, {27'd0, e.inst[20:16]});
        chk(e.nm, "stall",     {31'd0, stall}, {31'd0, e.stl});
        chk(e.nm, "pc_we",     {31'd0, pc_we}, {31'd0, ~e.stl});
        chk(e.nm, "stall_cnt", {28'd0, stall_cnt}, {28'd0, e.scnt});
        chk(e.nm, "flush_cnt", {28'd0, flush_cnt}, {28'd0, e.fcnt});
      end
    end
  end

  initial begin
    clr = 1'b1; if_inst = INST_A; if_pc = 32'h100; if_pc4 = 32'h104;
    pcsource = 2'b00; ex_m2reg = 1'b0; ex_wreg = 1'b0; ex_rd = 5'd0;
    // Reset for two edges, hazard-like EX inputs must not matter.
    step("reset1", 1, INST_A, 32'h100, 2'b00, 1, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0);
    step("reset2", 0, INST_A, 32'h0,   2'b00, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
    // Streaming.
    step("s1", 0, INST_B, 32'h4, 2'b00, 0, 0, 5'd0, INST_A, 32'h0, 32'h4, 1, 0, 0, 0);
    step("s2", 0, INST_C, 32'h8, 2'b00, 0, 0, 5'd0, INST_B, 32'h4, 32'h8, 1, 0, 0, 0);
    // Load-use on rt of add $3,$1,$2.
    step("lu",      0, INST_Z, 32'hC, 2'b00, 1, 1, 5'd2, INST_C, 32'h8, 32'hC, 1, 1, 0, 0);
    step("lu_hold", 0, INST_Z, 32'hC, 2'b00, 0, 0, 5'd0, INST_C, 32'h8, 32'hC, 1, 0, 1, 0);
    // ex_rd = 0 against rs = rt = 0: no stall.
    step("rd0",  0, INST_J, 32'h10, 2'b00, 1, 1, 5'd0, INST_Z, 32'hC, 32'h10, 1, 0, 1, 0);
    // j has rs/rt fields = 2 but reads no register; redirect issued here.
    step("j_nouse", 0, INST_D, 32'h14, 2'b01, 1, 1, 5'd2, INST_J, 32'h10, 32'h14, 1, 0, 1, 0);
    // Flushed slot: rd = 1 would match addi's rs were it kept.
    step("flushed", 0, INST_C, 32'h18, 2'b00, 1, 1, 5'd1, 32'h0, 32'h14, 32'h18, 0, 0, 1, 1);
    // Stall beats a jump redirect.
    step("svf",     0, INST_D, 32'h1C, 2'b10, 1, 1, 5'd1, INST_C, 32'h18, 32'h1C, 1, 1, 1, 1);
    step("svf_hold",0, INST_D, 32'h1C, 2'b00, 0, 0, 5'd0, INST_C, 32'h18, 32'h1C, 1, 0, 2, 1);
    // Reserved pcsource 11 is a redirect.
    step("ps11",    0, INST_C, 32'h20, 2'b11, 0, 0, 5'd0, INST_D, 32'h1C, 32'h20, 1, 0, 2, 1);
    step("ps11_fl", 0, INST_C, 32'h24, 2'b00, 0, 0, 5'd0, 32'h0, 32'h20, 32'h24, 0, 0, 2, 2);
    // 20 stall cycles: counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step("sat", 0, INST_D, 32'h28, 2'b01, 1, 1, 5'd2, INST_C, 32'h24, 32'h28, 1, 1,
           (i + 2 > 15) ? 4'd15 : 4'(i + 2), 4'd2);
    end
    step("sat_clr",  1, INST_D, 32'h28, 2'b01, 1, 1, 5'd2, INST_C, 32'h24, 32'h28, 1, 1, 15, 2);
    step("post_clr", 0, INST_D, 32'h28, 2'b00, 1, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0);
    step("final",    0, INST_B, 32'h2C, 2'b00, 0, 0, 5'd0, INST_D, 32'h28, 32'h2C, 1, 0, 0, 0);
    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
